// File: rtl/canny_thresh_sched.sv
// Frame scheduler for the Canny gradient-maximum tracker: clears and gates the
// tracker per frame, then derives and publishes hysteresis thresholds.
module canny_thresh_sched #(
    parameter int DW         = 20,
    parameter int HI_NUM     = 8,
    parameter int LO_NUM     = 8,
    parameter int MIN_HIGH   = 64,
    parameter int RESET_HIGH = 400,
    parameter int RESET_LOW  = 200
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_start,
    input  logic          frame_end,
    input  logic          mag_valid,
    input  logic [DW-1:0] trk_max,
    output logic          trk_rst,
    output logic          trk_en,
    output logic [DW-1:0] th_high,
    output logic [DW-1:0] th_low,
    output logic          th_update,
    output logic [DW-1:0] frame_max,
    output logic          empty_frame,
    output logic [15:0]   frame_cnt,
    output logic [7:0]    abort_cnt
);

    localparam int PW = DW + 5;

    localparam logic [PW-1:0] HI_K   = PW'(HI_NUM);
    localparam logic [PW-1:0] LO_K   = PW'(LO_NUM);
    localparam logic [DW-1:0] MIN_H  = DW'(MIN_HIGH);
    localparam logic [DW-1:0] RST_HI = DW'(RESET_HIGH);
    localparam logic [DW-1:0] RST_LO = DW'(RESET_LOW);

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        TRACK,
        CALC_HI,
        CALC_LO,
        PUB
    } state_t;

    state_t        state_q, state_d;
    logic          pend_q, pend_d;
    logic          seen_q, seen_d;
    logic [DW-1:0] hi_q, hi_d;
    logic [DW-1:0] lo_q, lo_d;
    logic [DW-1:0] th_high_q, th_high_d;
    logic [DW-1:0] th_low_q, th_low_d;
    logic [DW-1:0] frame_max_q, frame_max_d;
    logic          th_update_q, th_update_d;
    logic          empty_q, empty_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic [7:0]    abort_cnt_q, abort_cnt_d;

    // Ratios are at most 16/16, so the shifted products always fit DW bits.
    logic [PW-1:0] hi_prod;
    logic [PW-1:0] lo_prod;
    logic [DW-1:0] hi_raw;
    logic [DW-1:0] lo_raw;

    always_comb begin
        hi_prod = {5'd0, trk_max} * HI_K;
        lo_prod = {5'd0, hi_q} * LO_K;
        hi_raw  = DW'(hi_prod >> 4);
        lo_raw  = DW'(lo_prod >> 4);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pend_q      <= 1'b0;
            seen_q      <= 1'b0;
            hi_q        <= RST_HI;
            lo_q        <= RST_LO;
            th_high_q   <= RST_HI;
            th_low_q    <= RST_LO;
            frame_max_q <= '0;
            th_update_q <= 1'b0;
            empty_q     <= 1'b0;
            frame_cnt_q <= '0;
            abort_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            seen_q      <= seen_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            th_high_q   <= th_high_d;
            th_low_q    <= th_low_d;
            frame_max_q <= frame_max_d;
            th_update_q <= th_update_d;
            empty_q     <= empty_d;
            frame_cnt_q <= frame_cnt_d;
            abort_cnt_q <= abort_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        seen_d      = seen_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        th_high_d   = th_high_q;
        th_low_d    = th_low_q;
        frame_max_d = frame_max_q;
        th_update_d = 1'b0;
        empty_d     = 1'b0;
        frame_cnt_d = frame_cnt_q;
        abort_cnt_d = abort_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d = CLR;
                end
            end
            CLR: begin
                seen_d  = 1'b0;
                state_d = TRACK;
            end
            TRACK: begin
                if (mag_valid) begin
                    seen_d = 1'b1;
                end
                // A coincident frame_start belongs to the next frame.
                if (frame_end) begin
                    if (seen_q || mag_valid) begin
                        state_d = CALC_HI;
                        pend_d  = frame_start;
                    end else begin
                        empty_d = 1'b1;
                        pend_d  = 1'b0;
                        state_d = frame_start ? CLR : IDLE;
                    end
                end else if (frame_start) begin
                    state_d = CLR;
                    if (abort_cnt_q != 8'hFF) begin
                        abort_cnt_d = abort_cnt_q + 8'd1;
                    end
                end
            end
            CALC_HI: begin
                hi_d = (hi_raw < MIN_H) ? MIN_H : hi_raw;
                if (frame_start) begin
                    pend_d = 1'b1;
                end
                state_d = CALC_LO;
            end
            CALC_LO: begin
                lo_d = lo_raw;
                if (frame_start) begin
                    pend_d = 1'b1;
                end
                state_d = PUB;
            end
            PUB: begin
                th_high_d   = hi_q;
                th_low_d    = lo_q;
                frame_max_d = trk_max;
                th_update_d = 1'b1;
                frame_cnt_d = frame_cnt_q + 16'd1;
                state_d     = (pend_q || frame_start) ? CLR : IDLE;
                pend_d      = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign trk_rst     = rst || (state_q == CLR);
    assign trk_en      = (state_q == TRACK) && mag_valid;
    assign th_high     = th_high_q;
    assign th_low      = th_low_q;
    assign th_update   = th_update_q;
    assign frame_max   = frame_max_q;
    assign empty_frame = empty_q;
    assign frame_cnt   = frame_cnt_q;
    assign abort_cnt   = abort_cnt_q;

endmodule
